// File: rtl/matrix_input_parser.sv
// ASCII matrix parser: "M N e0 e1 ...\n" from a UART byte stream becomes dimension,
// element-write and frame-done strobes. A short line is zero-padded to M*N elements.
module matrix_input_parser #(
    parameter int unsigned MAX_DIM = 5,
    parameter int unsigned ELEM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              parse_en,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              dim_valid,
    output logic [2:0]        dim_m,
    output logic [2:0]        dim_n,
    output logic              elem_we,
    output logic [4:0]        elem_addr,
    output logic [ELEM_W-1:0] elem_data,
    output logic              frame_done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              busy
);

    typedef enum logic [2:0] {StIdle, StGetM, StGetN, StGetElem, StPad, StFlush} state_e;

    state_e            state_q, state_d;
    logic [8:0]        acc_q, acc_d;
    logic              tok_q, tok_d, neg_q, neg_d, dig_q, dig_d;
    logic [2:0]        m_q, m_d, dim_m_q, dim_m_d, dim_n_q, dim_n_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              dim_valid_q, dim_valid_d, elem_we_q, elem_we_d;
    logic              frame_done_q, frame_done_d, err_q, err_d;
    logic [4:0]        elem_addr_q, elem_addr_d;
    logic [ELEM_W-1:0] elem_data_q, elem_data_d;
    logic [1:0]        err_code_q, err_code_d;

    logic        fire, is_digit, is_minus, is_sep, is_lf;
    logic [3:0]  digit;
    logic [12:0] acc_mul;
    logic [8:0]  acc_sat;
    logic [7:0]  val8;
    logic [5:0]  total;
    logic        dim_ok, elem_ok;

    assign rx_ready = (state_q != StPad);
    assign busy     = (state_q != StIdle);
    assign fire     = rx_valid & rx_ready & parse_en;

    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_minus = (rx_data == 8'h2D);
    assign is_sep   = (rx_data == 8'h20) || (rx_data == 8'h0D);
    assign is_lf    = (rx_data == 8'h0A);
    assign digit    = rx_data[3:0];

    // Magnitude saturates at 256 so any oversize token stays out of range.
    assign acc_mul = 13'(acc_q) * 13'd10 + 13'(digit);
    assign acc_sat = (acc_mul > 13'd256) ? 9'd256 : acc_mul[8:0];

    assign dim_ok  = !neg_q && (acc_q != 9'd0) && (acc_q <= 9'(MAX_DIM));
    assign elem_ok = neg_q ? (acc_q <= 9'd128) : (acc_q <= 9'd127);
    assign val8    = neg_q ? (8'd0 - acc_q[7:0]) : acc_q[7:0];
    assign total   = 6'(dim_m_q) * 6'(dim_n_q);

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        tok_d        = tok_q;
        neg_d        = neg_q;
        dig_d        = dig_q;
        m_d          = m_q;
        dim_m_d      = dim_m_q;
        dim_n_d      = dim_n_q;
        cnt_d        = cnt_q;
        dim_valid_d  = 1'b0;
        elem_we_d    = 1'b0;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        elem_addr_d  = elem_addr_q;
        elem_data_d  = elem_data_q;
        err_code_d   = err_code_q;

        if (!parse_en) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (state_q == StPad) begin
            if (cnt_q < total) begin
                elem_we_d   = 1'b1;
                elem_addr_d = cnt_q[4:0];
                elem_data_d = '0;
                cnt_d       = cnt_q + 6'd1;
            end else begin
                frame_done_d = 1'b1;
                state_d      = StIdle;
            end
        end else if (fire) begin
            unique case (state_q)
                StIdle: begin
                    if (is_digit) begin
                        state_d = StGetM;
                        acc_d   = 9'(digit);
                        tok_d   = 1'b1;
                        dig_d   = 1'b1;
                    end else if (!(is_sep || is_lf)) begin
                        err_d      = 1'b1;
                        err_code_d = is_minus ? 2'd1 : 2'd0;
                        state_d    = StFlush;
                    end
                end
                StGetM: begin
                    if (is_digit) begin
                        acc_d = acc_sat;
                    end else if (is_sep && dim_ok) begin
                        m_d     = acc_q[2:0];
                        state_d = StGetN;
                        acc_d   = '0;
                        tok_d   = 1'b0;
                        dig_d   = 1'b0;
                    end else if (is_sep || is_lf) begin
                        err_d      = 1'b1;
                        err_code_d = dim_ok ? 2'd0 : 2'd1;
                        state_d    = is_lf ? StIdle : StFlush;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'd0;
                        state_d    = StFlush;
                    end
                end
                StGetN, StGetElem: begin
                    if (is_digit) begin
                        acc_d = tok_q ? acc_sat : 9'(digit);
                        tok_d = 1'b1;
                        dig_d = 1'b1;
                    end else if (is_minus) begin
                        if (tok_q) begin
                            err_d      = 1'b1;
                            err_code_d = 2'd0;
                            state_d    = StFlush;
                        end else begin
                            tok_d = 1'b1;
                            neg_d = 1'b1;
                            acc_d = '0;
                        end
                    end else if (is_sep || is_lf) begin
                        acc_d = '0;
                        tok_d = 1'b0;
                        neg_d = 1'b0;
                        dig_d = 1'b0;
                        if (!tok_q) begin
                            // Empty token: only LF has an effect.
                            if (is_lf && state_q == StGetN) begin
                                err_d      = 1'b1;
                                err_code_d = 2'd0;
                                state_d    = StIdle;
                            end else if (is_lf) begin
                                if (cnt_q == total) begin
                                    frame_done_d = 1'b1;
                                    state_d      = StIdle;
                                end else begin
                                    state_d = StPad;
                                end
                            end
                        end else if (!dig_q) begin
                            err_d      = 1'b1;
                            err_code_d = 2'd0;
                            state_d    = is_lf ? StIdle : StFlush;
                        end else if (state_q == StGetN) begin
                            if (!dim_ok) begin
                                err_d      = 1'b1;
                                err_code_d = 2'd1;
                                state_d    = is_lf ? StIdle : StFlush;
                            end else begin
                                dim_valid_d = 1'b1;
                                dim_m_d     = m_q;
                                dim_n_d     = acc_q[2:0];
                                cnt_d       = '0;
                                state_d     = is_lf ? StPad : StGetElem;
                            end
                        end else if (!elem_ok || cnt_q == total) begin
                            err_d      = 1'b1;
                            err_code_d = elem_ok ? 2'd3 : 2'd2;
                            state_d    = is_lf ? StIdle : StFlush;
                        end else begin
                            elem_we_d   = 1'b1;
                            elem_addr_d = cnt_q[4:0];
                            elem_data_d = ELEM_W'($signed(val8));
                            cnt_d       = cnt_q + 6'd1;
                            state_d     = is_lf ? StPad : StGetElem;
                        end
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'd0;
                        state_d    = StFlush;
                    end
                end
                StFlush: begin
                    if (is_lf) state_d = StIdle;
                end
                default: ;
            endcase
        end

        if (state_d == StIdle || state_d == StFlush) begin
            acc_d = '0;
            tok_d = 1'b0;
            neg_d = 1'b0;
            dig_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            tok_q        <= 1'b0;
            neg_q        <= 1'b0;
            dig_q        <= 1'b0;
            m_q          <= '0;
            dim_m_q      <= '0;
            dim_n_q      <= '0;
            cnt_q        <= '0;
            dim_valid_q  <= 1'b0;
            elem_we_q    <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            elem_addr_q  <= '0;
            elem_data_q  <= '0;
            err_code_q   <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            tok_q        <= tok_d;
            neg_q        <= neg_d;
            dig_q        <= dig_d;
            m_q          <= m_d;
            dim_m_q      <= dim_m_d;
            dim_n_q      <= dim_n_d;
            cnt_q        <= cnt_d;
            dim_valid_q  <= dim_valid_d;
            elem_we_q    <= elem_we_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            elem_addr_q  <= elem_addr_d;
            elem_data_q  <= elem_data_d;
            err_code_q   <= err_code_d;
        end
    end

    assign dim_valid  = dim_valid_q;
    assign dim_m      = dim_m_q;
    assign dim_n      = dim_n_q;
    assign elem_we    = elem_we_q;
    assign elem_addr  = elem_addr_q;
    assign elem_data  = elem_data_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_matrix_input_parser.sv
// Directed bench for matrix_input_parser: table of text lines with expected strobes,
// plus hand sequences for pad timing, parse_en abort and mid-frame reset.
module tb_matrix_input_parser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       parse_en = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready, dim_valid, elem_we, frame_done, err, busy;
    logic [2:0] dim_m, dim_n;
    logic [4:0] elem_addr;
    logic [7:0] elem_data;
    logic [1:0] err_code;

    matrix_input_parser dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .parse_en   (parse_en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .dim_valid  (dim_valid),
        .dim_m      (dim_m),
        .dim_n      (dim_n),
        .elem_we    (elem_we),
        .elem_addr  (elem_addr),
        .elem_data  (elem_data),
        .frame_done (frame_done),
        .err        (err),
        .err_code   (err_code),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         n_dim = 0, n_fd = 0, n_err = 0, n_viol = 0, fd_cyc = 0, last_code = 0;
    logic [4:0] wq_addr[$];
    logic [7:0] wq_data[$];
    int         wq_cyc[$];
    logic       wq_rdy[$];
    int         checks = 0, errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dim_valid) n_dim <= n_dim + 1;
        if (elem_we) begin
            wq_addr.push_back(elem_addr);
            wq_data.push_back(elem_data);
            wq_cyc.push_back(cyc);
            wq_rdy.push_back(rx_ready);
        end
        if (frame_done) begin
            n_fd   <= n_fd + 1;
            fd_cyc <= cyc;
        end
        if (err) begin
            n_err     <= n_err + 1;
            last_code <= int'(err_code);
        end
        if ((int'(elem_we) + int'(frame_done) + int'(err) > 1) || (dim_valid && elem_we))
            n_viol <= n_viol + 1;
    end

    typedef struct {
        string       text;
        int          dims;
        int          m;
        int          n;
        int          nw;
        logic [63:0] wd;
        int          frames;
        int          errs;
        int          code;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(string t, int d, int m, int n, int nw, logic [63:0] wd,
                                int fr, int er, int cd);
        vec_t v;
        v.text = t; v.dims = d; v.m = m; v.n = n; v.nw = nw; v.wd = wd;
        v.frames = fr; v.errs = er; v.code = cd;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        while (!rx_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_line(input string s);
        for (int k = 0; k < s.len(); k++) send_byte(s[k]);
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk({tag, "_idle"}, int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dim_valid"}, int'(dim_valid), 0);
        chk({tag, "_elem_we"}, int'(elem_we), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_dim_m"}, int'(dim_m), 0);
        chk({tag, "_dim_n"}, int'(dim_n), 0);
        chk({tag, "_elem_addr"}, int'(elem_addr), 0);
        chk({tag, "_elem_data"}, int'(elem_data), 0);
        chk({tag, "_err_code"}, int'(err_code), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_rx_ready"}, int'(rx_ready), 1);
    endtask

    initial begin
        int          b_dim, b_fd, b_err, b_w, nw_act;
        logic [63:0] w;
        string       tag;

        vq.push_back(mk("2 2 01 02 03 04\n", 1, 2, 2, 4, 64'h04030201, 1, 0, 0));
        vq.push_back(mk("2 3 -5 7\n",        1, 2, 3, 6, 64'h07FB,     1, 0, 0));
        vq.push_back(mk("6 2 1\n",           0, 2, 3, 0, 64'h0,        0, 1, 1));
        vq.push_back(mk("1 1 9\n",           1, 1, 1, 1, 64'h09,       1, 0, 0));
        vq.push_back(mk("1 1 200\n",         1, 1, 1, 0, 64'h0,        0, 1, 2));
        vq.push_back(mk("1 1 3 4\n",         1, 1, 1, 1, 64'h03,       0, 1, 3));
        vq.push_back(mk("2 2 1x 2\n",        1, 2, 2, 0, 64'h0,        0, 1, 0));
        vq.push_back(mk("  3 1\n",           1, 3, 1, 3, 64'h0,        1, 0, 0));
        vq.push_back(mk("-3 1\n",            0, 3, 1, 0, 64'h0,        0, 1, 1));
        vq.push_back(mk("1 2 -128 127\n",    1, 1, 2, 2, 64'h7F80,     1, 0, 0));
        vq.push_back(mk("1 1 -129\n",        1, 1, 1, 0, 64'h0,        0, 1, 2));
        vq.push_back(mk("2 1 5 - 3\n",       1, 2, 1, 1, 64'h05,       0, 1, 0));
        vq.push_back(mk("1 1 9999\n",        1, 1, 1, 0, 64'h0,        0, 1, 2));
        vq.push_back(mk("3\n",               0, 1, 1, 0, 64'h0,        0, 1, 0));
        vq.push_back(mk("1 3 4 5 6\015\n",   1, 1, 3, 3, 64'h060504,   1, 0, 0));

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("in_reset");
        rst_n    = 1'b1;
        parse_en = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("after_release");

        for (int i = 0; i < vq.size(); i++) begin
            tag   = $sformatf("v%0d", i);
            b_dim = n_dim; b_fd = n_fd; b_err = n_err; b_w = wq_addr.size();
            send_line(vq[i].text);
            wait_idle(tag);
            nw_act = wq_addr.size() - b_w;
            chk({tag, "_dims"}, n_dim - b_dim, vq[i].dims);
            chk({tag, "_dim_m"}, int'(dim_m), vq[i].m);
            chk({tag, "_dim_n"}, int'(dim_n), vq[i].n);
            chk({tag, "_writes"}, nw_act, vq[i].nw);
            w = vq[i].wd;
            for (int j = 0; j < vq[i].nw && j < nw_act; j++) begin
                chk($sformatf("%s_addr%0d", tag, j), int'(wq_addr[b_w + j]), j);
                chk($sformatf("%s_data%0d", tag, j), int'(wq_data[b_w + j]),
                    int'(w[8*j +: 8]));
            end
            chk({tag, "_frames"}, n_fd - b_fd, vq[i].frames);
            chk({tag, "_errs"}, n_err - b_err, vq[i].errs);
            if (vq[i].errs > 0) chk({tag, "_code"}, last_code, vq[i].code);
        end

        // Zero padding: consecutive cycles, rx_ready low, frame_done right after.
        b_fd = n_fd; b_w = wq_addr.size();
        send_line("2 3 -5 7\n");
        wait_idle("pad");
        chk("pad_writes", wq_addr.size() - b_w, 6);
        if (wq_addr.size() - b_w == 6) begin
            for (int k = 2; k < 6; k++) begin
                chk($sformatf("pad_ready%0d", k), int'(wq_rdy[b_w + k]), 0);
                chk($sformatf("pad_data%0d", k), int'(wq_data[b_w + k]), 0);
            end
            for (int k = 2; k < 5; k++)
                chk($sformatf("pad_gap%0d", k), wq_cyc[b_w + k + 1] - wq_cyc[b_w + k], 1);
            chk("pad_fd_gap", fd_cyc - wq_cyc[b_w + 5], 1);
        end
        chk("pad_frames", n_fd - b_fd, 1);

        // parse_en abort mid-frame.
        b_w = wq_addr.size();
        send_line("3 3 1 2 ");
        repeat (2) @(posedge clk);
        #1;
        chk("abort_pre_writes", wq_addr.size() - b_w, 2);
        chk("abort_pre_busy", int'(busy), 1);
        b_dim = n_dim; b_fd = n_fd; b_err = n_err; b_w = wq_addr.size();
        parse_en = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", int'(busy), 0);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_dims", n_dim - b_dim, 0);
        chk("abort_writes", wq_addr.size() - b_w, 0);
        chk("abort_frames", n_fd - b_fd, 0);
        chk("abort_errs", n_err - b_err, 0);
        parse_en = 1'b1;
        b_fd = n_fd; b_w = wq_addr.size();
        send_line("1 1 9\n");
        wait_idle("rearm");
        chk("rearm_writes", wq_addr.size() - b_w, 1);
        if (wq_addr.size() - b_w == 1) chk("rearm_data", int'(wq_data[b_w]), 9);
        chk("rearm_frames", n_fd - b_fd, 1);

        // Reset in the middle of a frame.
        send_line("2 2 5 ");
        repeat (2) @(posedge clk);
        #1;
        chk("mid_busy", int'(busy), 1);
        chk("mid_data", int'(elem_data), 5);
        rst_n = 1'b0;
        #2;
        chk_reset_vals("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        b_dim = n_dim; b_fd = n_fd; b_err = n_err; b_w = wq_addr.size();
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_dims", n_dim - b_dim, 0);
        chk("post_rst_writes", wq_addr.size() - b_w, 0);
        chk("post_rst_frames", n_fd - b_fd, 0);
        chk("post_rst_errs", n_err - b_err, 0);

        chk("strobe_exclusive", n_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
